imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
Fetch sequencer for the synchronous-read instruction ROM/RAM. It generates word addresses from a fetch PC, tracks in-flight reads, and buffers returned instructions with their PCs in a small prefetch FIFO. It delivers instructions to the core over a valid/ready handshake and handles redirects (branch/exception) by flushing the FIFO. It sits between the core front-end and the IMEM array.

Parameters:
IMEM_WIDTH, 32, instruction word width.
IMEM_DEPTH, 8192, IMEM words; AW = $clog2(IMEM_DEPTH).
FIFO_DEPTH, 4, prefetch entries (power of two, >=2).
RESET_PC, 32'h0000_0000, first fetch PC after reset.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
fetch_en  in  1  allows new IMEM requests when high.
redirect_valid  in  1  one-cycle pulse to redirect fetch.
redirect_pc  in  32  new PC; bits [1:0] ignored.
instr_valid  out  1  FIFO head valid.
instr_ready  in  1  core accepts head.
instr_data  out  IMEM_WIDTH  head instruction.
instr_pc  out  32  head PC.
imem_req  out  1  read strobe.
imem_addr  out  AW  word address = pc[AW+1:2] (upper PC bits ignored; wraps modulo IMEM_DEPTH).
imem_rdata  in  IMEM_WIDTH  read data, valid exactly 1 cycle after imem_req.
busy  out  1  high when a read is in flight or the FIFO is non-empty.

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low. On reset: fetch_pc=RESET_PC, FIFO empty, inflight=0, state=IDLE. All outputs are 0.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN when fetch_en=1.
  - RUN -> DRAIN when fetch_en=0.
  - DRAIN -> IDLE when inflight=0.
  - DRAIN -> RUN when fetch_en returns to 1.
- Issue rule, RUN only: imem_req=1 when (count + inflight) < FIFO_DEPTH and redirect_valid=0.
  - imem_addr = fetch_pc[AW+1:2].
  - fetch_pc += 4 on each issue (32-bit wrap). req_pc is captured.
- Response: the cycle after a request, {imem_rdata, req_pc} is pushed into the FIFO unless killed. Space is guaranteed by the issue rule, so the FIFO never overflows.
- Pop: occurs when instr_valid && instr_ready.
  - Push and pop in the same cycle is legal, count is unchanged.
  - A full FIFO with a pop permits a new issue the same cycle.
- Peak throughput is 1 instruction/cycle. First instruction latency after a fetch_en rise: request at cycle N+1, instr_valid at N+2.
- Redirect (any state):
  - Same cycle: FIFO flushed, no request issued, any response arriving next cycle is killed, fetch_pc <= {redirect_pc[31:2],2'b00}.
  - Next cycle: instr_valid=0. Fetch resumes next cycle if RUN.
  - Redirect takes priority over a simultaneous pop; the popped head is still consumed by the core.
- instr_data/instr_pc are stable while instr_valid=1 and instr_ready=0.
- Reset mid-operation: an in-flight response is discarded and the FIFO is emptied.

Optional Feature:
IMEM_LOADER_EN.
- With it defined, added ports: ld_valid in 1, ld_ready out 1, ld_addr in AW, ld_data in IMEM_WIDTH, imem_we out 1, imem_wdata out IMEM_WIDTH.
- Added state LOAD, entered from any state when ld_valid=1. Issuing stops; ld_ready=1 only once inflight=0. Each ld_valid&&ld_ready drives imem_we=1 with imem_addr=ld_addr for one write.
- On exit (ld_valid=0): FIFO flushed, fetch_pc set to the PC of the oldest unconsumed instruction (or current fetch_pc if the FIFO was empty), return to RUN/IDLE per fetch_en.
- Loader outranks fetch but not redirect; a simultaneous redirect sets the restart PC.
- Without the macro, the ports and LOAD state are absent.

Decomposition:
- Package imem_pkg holds:
  - the fetch_state_e enum (IDLE, RUN, DRAIN, LOAD);
  - the fetch_entry_t struct {instr, pc};
  - the IMEM_WIDTH/IMEM_DEPTH defaults;
  - the RESET_PC constant.
- One sub-module, fetch_fifo: synchronous FIFO of fetch_entry_t with flush, push, pop, count, full and empty.

Test Plan:
- Reset release with fetch_en=1, instr_ready=1, IMEM preloaded word i = 32'hA000_0000+i -> after 2 cycles, one instruction per cycle: PC=0x00 INSTR=A0000000, PC=0x04 INSTR=A0000001, … for 16 words.
- instr_ready=0 for 10 cycles -> exactly 4 requests issued, count=4, imem_req held 0, head stays PC=0x00. Release -> in-order delivery with no loss or duplicates.
- redirect_valid with redirect_pc=0x0000_0103 while the FIFO holds 3 entries and 1 is in flight -> next cycle instr_valid=0. The first delivered instruction has PC=0x100 and data word 0x40. The in-flight response is dropped.
- fetch_en low mid-stream -> the in-flight response completes and busy stays high until the FIFO drains, then state=IDLE. No imem_req while fetch_en=0.
- fetch_pc = 0x0000_7FFC with IMEM_DEPTH=8192 -> imem_addr=0x1FFF, then imem_addr=0x0000 with instr_pc=0x0000_8000.
- IMEM_LOADER_EN: ld_valid asserted during streaming, write addr 0x5 = 32'hDEAD_BEEF -> ld_ready rises only after inflight=0. Restart refetches from the oldest unconsumed PC, and PC=0x14 returns DEADBEEF.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
// IMEM_LOADER_EN adds the LOAD state used by the IMEM loader.
package imem_pkg;

  localparam int unsigned ImemWidthDef = 32;
  localparam int unsigned ImemDepthDef = 8192;
  localparam logic [31:0] ResetPcDef   = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
`ifdef IMEM_LOADER_EN
    StDrain,
    StLoad
`else
    StDrain
`endif
  } fetch_state_e;

  typedef struct packed {
    logic [ImemWidthDef-1:0] instr;
    logic [31:0]             pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {instr, pc} entries; flush outranks push and pop.
module fetch_fifo
  import imem_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  fetch_entry_t    data_i,
  input  logic            pop_i,
  output fetch_entry_t    data_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o
);

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: issues IMEM reads, buffers responses, delivers over valid/ready.
// Optional IMEM_LOADER_EN adds a loader write port and the LOAD state.
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned  IMEM_WIDTH = ImemWidthDef,
  parameter int unsigned  IMEM_DEPTH = ImemDepthDef,
  parameter int unsigned  FIFO_DEPTH = 4,
  parameter logic [31:0]  RESET_PC   = ResetPcDef,
  localparam int unsigned AW         = $clog2(IMEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [IMEM_WIDTH-1:0] instr_data,
  output logic [31:0]           instr_pc,
  output logic                  imem_req,
  output logic [AW-1:0]         imem_addr,
  input  logic [IMEM_WIDTH-1:0] imem_rdata,
`ifdef IMEM_LOADER_EN
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [AW-1:0]         ld_addr,
  input  logic [IMEM_WIDTH-1:0] ld_data,
  output logic                  imem_we,
  output logic [IMEM_WIDTH-1:0] imem_wdata,
`endif
  output logic                  busy
);

  localparam int unsigned CntW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW:0] DepthC = (CntW + 1)'(FIFO_DEPTH);

  fetch_state_e    state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     req_pc_q;
  logic            inflight_q;
  logic            issue, pop, loading, ld_block, load_exit;
  logic            fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic [CntW:0]   occupancy;
  fetch_entry_t    resp_entry, fifo_head, head;
  logic            unused_rpc;

  assign unused_rpc = ^redirect_pc[1:0];

`ifdef IMEM_LOADER_EN
  assign loading    = (state_q == StLoad);
  assign ld_block   = ld_valid;
  assign ld_ready   = loading && !inflight_q;
  assign imem_we    = ld_valid && ld_ready;
  assign imem_wdata = ld_data;
`else
  assign loading    = 1'b0;
  assign ld_block   = 1'b0;
`endif

  assign resp_entry = '{instr: imem_rdata, pc: req_pc_q};

  // A response arriving into an empty FIFO is presented directly to the core.
  assign head        = fifo_empty ? resp_entry : fifo_head;
  assign instr_valid = (!fifo_empty || inflight_q) && !loading;
  assign pop         = instr_valid && instr_ready;
  assign fifo_pop    = pop && !fifo_empty;
  assign fifo_push   = inflight_q && !(fifo_empty && pop);
  assign fifo_flush  = redirect_valid || load_exit;

  assign instr_data = instr_valid ? head.instr : '0;
  assign instr_pc   = instr_valid ? head.pc : '0;
  assign busy       = inflight_q || !fifo_empty;

  // Slots already claimed after this cycle's pop; a pop frees a slot for a same-cycle issue.
  assign occupancy = {1'b0, fifo_count} + {{CntW{1'b0}}, inflight_q} - {{CntW{1'b0}}, pop};

  assign issue = (state_q == StRun) && fetch_en && !redirect_valid && !ld_block &&
                 (occupancy < DepthC) && (!fifo_full || fifo_pop);

  assign imem_req = issue;

  always_comb begin
    imem_addr = '0;
    if (issue) imem_addr = fetch_pc_q[AW+1:2];
`ifdef IMEM_LOADER_EN
    if (imem_we) imem_addr = ld_addr;
`endif
  end

  always_comb begin
    state_d   = state_q;
    load_exit = 1'b0;
    unique case (state_q)
      StIdle:  if (fetch_en) state_d = StRun;
      StRun:   if (!fetch_en) state_d = StDrain;
      StDrain: begin
        if (fetch_en)         state_d = StRun;
        else if (!inflight_q) state_d = StIdle;
      end
`ifdef IMEM_LOADER_EN
      StLoad: begin
        if (!ld_valid && !inflight_q) begin
          load_exit = 1'b1;
          state_d   = fetch_en ? StRun : StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
`ifdef IMEM_LOADER_EN
    if (ld_valid) state_d = StLoad;
`endif
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else if (load_exit) begin
      // Restart from the oldest instruction the core has not yet taken.
      fetch_pc_d = fifo_empty ? fetch_pc_q : fifo_head.pc;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= issue;
      if (issue) req_pc_q <= fetch_pc_q;
    end
  end

  fetch_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .data_i  (resp_entry),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a synchronous-read IMEM model.
module tb_imem_fetch_ctrl;
  import imem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        imem_req;
  logic [12:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        busy;
`ifdef IMEM_LOADER_EN
  logic        ld_valid;
  logic        ld_ready;
  logic [12:0] ld_addr;
  logic [31:0] ld_data;
  logic        imem_we;
  logic [31:0] imem_wdata;
`endif

  int total = 0;
  int bad   = 0;
  logic patched = 1'b0;

  logic        patch_en   = 1'b0;
  logic [12:0] patch_addr = '0;
  logic [31:0] patch_val  = '0;

  logic [31:0] got_pc[$];
  logic [31:0] got_data[$];

  imem_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
`ifdef IMEM_LOADER_EN
    .ld_valid       (ld_valid),
    .ld_ready       (ld_ready),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data),
    .imem_we        (imem_we),
    .imem_wdata     (imem_wdata),
`endif
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // IMEM word i holds A000_0000 + i unless the loader overwrote it.
  always @(posedge clk) begin
    if (imem_req)
      imem_rdata <= (patch_en && imem_addr == patch_addr) ? patch_val
                                                         : 32'hA000_0000 + {19'd0, imem_addr};
`ifdef IMEM_LOADER_EN
    if (imem_we) begin
      patch_en   <= 1'b1;
      patch_addr <= imem_addr;
      patch_val  <= imem_wdata;
    end
`endif
  end

  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready) begin
      got_pc.push_back(instr_pc);
      got_data.push_back(instr_data);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_word(input logic [31:0] pc);
    if (patched && pc[14:2] == 13'd5) return 32'hDEAD_BEEF;
    return 32'hA000_0000 + {19'd0, pc[14:2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_deliveries(input int n, input int budget);
    int k = 0;
    while (got_pc.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while ((busy || dut.state_q != StIdle) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_req(input string tag);
    int k = 0;
    @(negedge clk);
    while (!imem_req && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk(tag, {31'd0, imem_req}, 32'd1);
  endtask

  task automatic check_stream(input string tag, input logic [31:0] base, input int min_n);
    logic [31:0] pc;
    pc = base;
    chk({tag, "_count"}, 32'(got_pc.size() >= min_n), 32'd1);
    foreach (got_pc[i]) begin
      chk({tag, "_pc"}, got_pc[i], pc);
      chk({tag, "_data"}, got_data[i], exp_word(pc));
      pc += 32'd4;
    end
    got_pc.delete();
    got_data.delete();
  endtask

  initial begin
    int nreq;
    rst_n          = 1'b0;
    fetch_en       = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
`ifdef IMEM_LOADER_EN
    ld_valid = 1'b0;
    ld_addr  = '0;
    ld_data  = '0;
`endif

    // Reset state
    #2;
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_addr", {19'd0, imem_addr}, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
    chk("rst_data", instr_data, 32'd0);

    // Streaming from reset: request one cycle after release, data the next
    #10 rst_n = 1'b1;
    @(negedge clk);
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", {19'd0, imem_addr}, 32'd0);
    chk("first_valid_early", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    chk("first_valid", {31'd0, instr_valid}, 32'd1);
    chk("first_pc", instr_pc, 32'h0);
    chk("first_data", instr_data, 32'hA000_0000);
    wait_deliveries(16, 40);

    // fetch_en low with core stalled: no requests, busy held while FIFO holds data
    step();
    fetch_en    = 1'b0;
    instr_ready = 1'b0;
    nreq = 0;
    repeat (5) begin
      @(negedge clk);
      if (imem_req) nreq++;
    end
    chk("drain_nreq", nreq, 32'd0);
    chk("drain_busy", {31'd0, busy}, 32'd1);
    chk("drain_state", {30'd0, dut.state_q}, {30'd0, StIdle});
    step();
    instr_ready = 1'b1;
    wait_idle("drain_idle");
    check_stream("stream", 32'h0, 17);

    // Back-pressure: exactly FIFO_DEPTH requests, head held
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    instr_ready    = 1'b0;
    step();
    redirect_valid = 1'b0;
    fetch_en       = 1'b1;
    nreq = 0;
    repeat (10) begin
      @(negedge clk);
      if (imem_req) nreq++;
    end
    chk("stall_nreq", nreq, 32'd4);
    chk("stall_req", {31'd0, imem_req}, 32'd0);
    chk("stall_count", {29'd0, dut.u_fifo.count_o}, 32'd4);
    chk("stall_valid", {31'd0, instr_valid}, 32'd1);
    chk("stall_pc", instr_pc, 32'h200);
    chk("stall_data", instr_data, 32'hA000_0080);
    step();
    instr_ready = 1'b1;
    wait_deliveries(8, 30);
    check_stream("stall_rel", 32'h200, 8);

    // Redirect with 3 entries queued and 1 response arriving
    step();
    fetch_en = 1'b0;
    wait_idle("redir_idle");
    got_pc.delete();
    got_data.delete();
    step();
    instr_ready = 1'b0;
    fetch_en    = 1'b1;
    wait_req("redir_t1");
    repeat (4) @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    @(negedge clk);
    chk("redir_count", {29'd0, dut.u_fifo.count_o}, 32'd3);
    chk("redir_inflight", {31'd0, dut.inflight_q}, 32'd1);
    chk("redir_noreq", {31'd0, imem_req}, 32'd0);
    step();
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    @(negedge clk);
    chk("redir_valid0", {31'd0, instr_valid}, 32'd0);
    chk("redir_addr", {19'd0, imem_addr}, 32'h40);
    wait_deliveries(4, 20);
    check_stream("redir", 32'h100, 4);

    // Address wrap modulo IMEM_DEPTH
    step();
    fetch_en = 1'b0;
    wait_idle("wrap_idle");
    got_pc.delete();
    got_data.delete();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_7FFC;
    step();
    redirect_valid = 1'b0;
    fetch_en       = 1'b1;
    wait_req("wrap_req");
    chk("wrap_addr_hi", {19'd0, imem_addr}, 32'h1FFF);
    @(negedge clk);
    chk("wrap_req2", {31'd0, imem_req}, 32'd1);
    chk("wrap_addr_lo", {19'd0, imem_addr}, 32'h0);
    wait_deliveries(2, 20);
    check_stream("wrap", 32'h7FFC, 2);

`ifdef IMEM_LOADER_EN
    // Loader write mid-stream, restart from oldest unconsumed PC
    step();
    fetch_en = 1'b0;
    wait_idle("ld_idle");
    got_pc.delete();
    got_data.delete();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;
    step();
    redirect_valid = 1'b0;
    fetch_en       = 1'b1;
    wait_req("ld_t1");
    repeat (3) @(posedge clk);
    #1;
    ld_valid = 1'b1;
    ld_addr  = 13'h5;
    ld_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("ld_ready0", {31'd0, ld_ready}, 32'd0);
    chk("ld_inflight", {31'd0, dut.inflight_q}, 32'd1);
    chk("ld_noreq", {31'd0, imem_req}, 32'd0);
    step();
    @(negedge clk);
    chk("ld_ready1", {31'd0, ld_ready}, 32'd1);
    chk("ld_we", {31'd0, imem_we}, 32'd1);
    chk("ld_addr", {19'd0, imem_addr}, 32'h5);
    step();
    ld_valid    = 1'b0;
    instr_ready = 1'b1;
    patched     = 1'b1;
    wait_deliveries(8, 30);
    check_stream("ld", 32'h0, 8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
